// File: rtl/button_debounce.sv
// Synchronises and debounces raw push-button pins into clean active-high levels with press/release strobes.
// Latency: DEBOUNCE_CYCLES+2 edges from a stable pin change to btn_out and strobe. There is no backpressure.
module button_debounce #(
  parameter int WIDTH           = 4,
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] key_n;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  assign key_n = ACTIVE_LOW ? ~key_raw : key_raw;

  // Two back-to-back flops; only s1 may go metastable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [CNT_W-1:0] cnt;
    logic             stable;
    logic             press_q;
    logic             release_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt       <= '0;
        stable    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (s2[i] == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          // New level has persisted long enough: accept it and strobe once.
          stable    <= s2[i];
          cnt       <= '0;
          press_q   <= s2[i];
          release_q <= ~s2[i];
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign btn_out[i]       = stable;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, one active-low and one active-high instance.
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key_raw;
  logic [3:0] btn_out, press_pulse, release_pulse;
  logic [3:0] key_raw_p;
  logic [3:0] btn_out_p, press_pulse_p, release_pulse_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_debounce #(.WIDTH(4), .CNT_W(20), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .key_raw       (key_raw),
    .btn_out       (btn_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  button_debounce #(.WIDTH(4), .CNT_W(20), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_p (
    .clk           (clk),
    .reset_n       (reset_n),
    .key_raw       (key_raw_p),
    .btn_out       (btn_out_p),
    .press_pulse   (press_pulse_p),
    .release_pulse (release_pulse_p)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    key_raw   = 4'hF;
    key_raw_p = 4'h0;
    repeat (3) tick();
    check("in_reset", {btn_out, press_pulse, release_pulse}, 12'h000);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("idle_after_reset", {btn_out, press_pulse, release_pulse}, 12'h000);
    end

    // Clean press and release on channel 0
    key_raw[0] = 1'b0;
    repeat (5) tick();
    check("press_e5_btn", btn_out, 4'h0);
    check("press_e5_pulse", press_pulse, 4'h0);
    tick();
    check("press_e6_btn", btn_out, 4'h1);
    check("press_e6_pulse", press_pulse, 4'h1);
    check("press_e6_rel", release_pulse, 4'h0);
    tick();
    check("press_e7_pulse", press_pulse, 4'h0);
    check("press_e7_btn", btn_out, 4'h1);
    key_raw[0] = 1'b1;
    repeat (5) tick();
    check("rel_e5_btn", btn_out, 4'h1);
    check("rel_e5_pulse", release_pulse, 4'h0);
    tick();
    check("rel_e6_btn", btn_out, 4'h0);
    check("rel_e6_pulse", release_pulse, 4'h1);
    check("rel_e6_press", press_pulse, 4'h0);
    tick();
    check("rel_e7_pulse", release_pulse, 4'h0);

    // Bounce on channel 1: 3-cycle lows reach cnt=D-1 but are never accepted
    for (int r = 0; r < 5; r++) begin
      key_raw[1] = 1'b0;
      repeat (3) begin
        tick();
        check("bounce_quiet", {btn_out, press_pulse, release_pulse}, 12'h000);
      end
      key_raw[1] = 1'b1;
      tick();
      check("bounce_quiet", {btn_out, press_pulse, release_pulse}, 12'h000);
    end
    key_raw[1] = 1'b0;
    repeat (5) begin
      tick();
      check("bounce_hold_wait", {btn_out, press_pulse, release_pulse}, 12'h000);
    end
    tick();
    check("bounce_e6_btn", btn_out, 4'h2);
    check("bounce_e6_pulse", press_pulse, 4'h2);

    // Channels 2 and 3 pressed together
    key_raw[3:2] = 2'b00;
    repeat (5) tick();
    check("simul_e5_pulse", press_pulse, 4'h0);
    tick();
    check("simul_e6_pulse", press_pulse, 4'hC);
    check("simul_e6_btn", btn_out, 4'hE);
    tick();
    check("simul_e7_pulse", press_pulse, 4'h0);
    check("simul_e7_btn", btn_out, 4'hE);

    // Reset while channel 0 is mid-debounce (cnt=2 after E4)
    key_raw[0] = 1'b0;
    repeat (4) tick();
    check("mid_pre_btn", btn_out, 4'hE);
    reset_n = 1'b0;
    #1;
    check("mid_async_btn", btn_out, 4'h0);
    check("mid_async_pulses", {press_pulse, release_pulse}, 8'h00);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (5) begin
      tick();
      check("mid_wait", {btn_out, press_pulse, release_pulse}, 12'h000);
    end
    tick();
    check("mid_e6_pulse", press_pulse, 4'hF);
    check("mid_e6_btn", btn_out, 4'hF);
    tick();
    check("mid_e7_pulse", press_pulse, 4'h0);

    // Active-high polarity instance
    check("pol_idle_btn", btn_out_p, 4'h0);
    key_raw_p = 4'h5;
    repeat (5) tick();
    check("pol_e5_btn", btn_out_p, 4'h0);
    tick();
    check("pol_e6_btn", btn_out_p, 4'h5);
    check("pol_e6_pulse", press_pulse_p, 4'h5);
    check("pol_e6_rel", release_pulse_p, 4'h0);
    tick();
    check("pol_e7_pulse", press_pulse_p, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
